// File: rtl/axis_32to64_strb_tuser_pkg.sv
// rtl/axis_32to64_strb_tuser_pkg.sv - shared types and constants for the 32-to-64 AXIS packer
//
// Purpose: input state encoding and output byte-strobe constants used by the
//          32-to-64 bit packer with header-to-TUSER extraction.
package axis_32to64_strb_tuser_pkg;

    // Input-side position within a packet: waiting for the header word,
    // for the low word of a 64-bit beat, or for its high word.
    typedef enum logic [1:0] {
        S_HDR = 2'd0,
        S_LO  = 2'd1,
        S_HI  = 2'd2
    } state_t;

    localparam logic [7:0] STRB_FULL  = 8'hFF;
    localparam logic [7:0] STRB_LOW   = 8'h0F;
    localparam logic [7:0] STRB_EMPTY = 8'h00;

endpackage

// File: rtl/axis_32to64_strb_tuser.sv
// rtl/axis_32to64_strb_tuser.sv - AXIS 32-to-64 packer, header word exported on TUSER
//
// Purpose: the first 32-bit word of each input packet is captured as the
//          packet header and presented on M_AXIS_TUSER; the remaining words
//          are packed in pairs into 64-bit beats (earlier word in [31:0]).
//          An odd trailing word gives a half beat (TSTRB=0F); a header-only
//          packet gives one empty beat (TDATA=0, TSTRB=00, TLAST=1).
// Ports:
//   AXIS_ACLK, AXIS_ARESET         clock, synchronous active-high reset
//   S_AXIS_TDATA/TVALID/TLAST      32-bit slave stream in
//   S_AXIS_TREADY                  slave ready out
//   M_AXIS_TDATA/TSTRB/TUSER/      64-bit master stream out with strobes
//   TLAST/TVALID                   and packet header
//   M_AXIS_TREADY                  master ready in
module axis_32to64_strb_tuser
    import axis_32to64_strb_tuser_pkg::*;
(
    input  logic        AXIS_ACLK,
    input  logic        AXIS_ARESET,
    output logic        S_AXIS_TREADY,
    input  logic [31:0] S_AXIS_TDATA,
    input  logic        S_AXIS_TLAST,
    input  logic        S_AXIS_TVALID,
    output logic        M_AXIS_TVALID,
    output logic [63:0] M_AXIS_TDATA,
    output logic [7:0]  M_AXIS_TSTRB,
    output logic [31:0] M_AXIS_TUSER,
    output logic        M_AXIS_TLAST,
    input  logic        M_AXIS_TREADY
);

    state_t      state_q, state_d;
    logic [31:0] low_q, low_d;
    logic        m_tvalid_q, m_tvalid_d;
    logic [63:0] m_tdata_q, m_tdata_d;
    logic [7:0]  m_tstrb_q, m_tstrb_d;
    logic [31:0] m_tuser_q, m_tuser_d;
    logic        m_tlast_q, m_tlast_d;

    logic s_tready;
    logic s_xfer;
    logic m_xfer;

    always_comb begin
        state_d    = state_q;
        low_d      = low_q;
        m_tdata_d  = m_tdata_q;
        m_tstrb_d  = m_tstrb_q;
        m_tuser_d  = m_tuser_q;
        m_tlast_d  = m_tlast_q;

        m_xfer = m_tvalid_q && M_AXIS_TREADY;

        // The header is only taken once the previous packet's last beat has
        // fully left, so TUSER never changes under a pending beat. Data words
        // may be taken while the output register is being emptied.
        if (state_q == S_HDR) begin
            s_tready = !m_tvalid_q;
        end else begin
            s_tready = !m_tvalid_q || M_AXIS_TREADY;
        end
        s_xfer = S_AXIS_TVALID && s_tready;

        m_tvalid_d = m_tvalid_q && !m_xfer;

        if (s_xfer) begin
            case (state_q)
                S_HDR: begin
                    m_tuser_d = S_AXIS_TDATA;
                    if (S_AXIS_TLAST) begin
                        m_tvalid_d = 1'b1;
                        m_tdata_d  = 64'h0;
                        m_tstrb_d  = STRB_EMPTY;
                        m_tlast_d  = 1'b1;
                        state_d    = S_HDR;
                    end else begin
                        state_d    = S_LO;
                    end
                end
                S_LO: begin
                    if (S_AXIS_TLAST) begin
                        m_tvalid_d = 1'b1;
                        m_tdata_d  = {32'h0, S_AXIS_TDATA};
                        m_tstrb_d  = STRB_LOW;
                        m_tlast_d  = 1'b1;
                        state_d    = S_HDR;
                    end else begin
                        low_d      = S_AXIS_TDATA;
                        state_d    = S_HI;
                    end
                end
                S_HI: begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = {S_AXIS_TDATA, low_q};
                    m_tstrb_d  = STRB_FULL;
                    m_tlast_d  = S_AXIS_TLAST;
                    state_d    = S_AXIS_TLAST ? S_HDR : S_LO;
                end
                default: begin
                    state_d = S_HDR;
                end
            endcase
        end
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            state_q    <= S_HDR;
            low_q      <= 32'h0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= 64'h0;
            m_tstrb_q  <= 8'h0;
            m_tuser_q  <= 32'h0;
            m_tlast_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            low_q      <= low_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tstrb_q  <= m_tstrb_d;
            m_tuser_q  <= m_tuser_d;
            m_tlast_q  <= m_tlast_d;
        end
    end

    assign S_AXIS_TREADY = s_tready;
    assign M_AXIS_TVALID = m_tvalid_q;
    assign M_AXIS_TDATA  = m_tdata_q;
    assign M_AXIS_TSTRB  = m_tstrb_q;
    assign M_AXIS_TUSER  = m_tuser_q;
    assign M_AXIS_TLAST  = m_tlast_q;

endmodule

// File: doc/axis_32to64_strb_tuser.md
AXIS_32TO64_STRB_TUSER -- requirements
Module: axis_32to64_strb_tuser

Interface
REQ-001 Parameters SHALL be none; all widths are fixed as listed below.
REQ-002 AXIS_ACLK  input  1  single clock; all logic SHALL be synchronous to its rising edge.
REQ-003 AXIS_ARESET  input  1  reset, synchronous, active-high.
REQ-004 S_AXIS_TREADY  output  1  slave ready.
REQ-005 S_AXIS_TDATA  input  32  slave data; first beat of each packet is the header word.
REQ-006 S_AXIS_TLAST  input  1  slave end of packet.
REQ-007 S_AXIS_TVALID  input  1  slave valid.
REQ-008 M_AXIS_TVALID  output  1  master valid.
REQ-009 M_AXIS_TDATA  output  64  packed data, earlier word in [31:0], later word in [63:32].
REQ-010 M_AXIS_TSTRB  output  8  byte strobes for M_AXIS_TDATA.
REQ-011 M_AXIS_TUSER  output  32  packet header word.
REQ-012 M_AXIS_TLAST  output  1  master end of packet.
REQ-013 M_AXIS_TREADY  input  1  master ready.

Function
REQ-014 Transfers SHALL occur only on cycles where VALID and READY are both high, on either port.
REQ-015 The input state machine SHALL have states S_HDR, S_LO and S_HI, and SHALL reset to S_HDR.
REQ-016 S_HDR SHALL drive S_AXIS_TREADY = !M_AXIS_TVALID.
REQ-017 On an S_HDR transfer, the block SHALL load TDATA into the TUSER register.
REQ-018 On an S_HDR transfer, the state SHALL go to S_LO, or SHALL stay in S_HDR if TLAST=1 (see REQ-025).
REQ-019 S_LO and S_HI SHALL drive S_AXIS_TREADY = !M_AXIS_TVALID || M_AXIS_TREADY.
REQ-020 An S_LO transfer without TLAST SHALL latch TDATA as the low word and go to S_HI.
REQ-021 An S_LO transfer with TLAST SHALL load the output register with {32'h0, TDATA}, TSTRB=8'h0F, TLAST=1, and go to S_HDR.
REQ-022 An S_HI transfer SHALL load the output register with {TDATA, low word}, TSTRB=8'hFF, TLAST=S_AXIS_TLAST.
REQ-023 After an S_HI transfer, the state SHALL go to S_HDR if TLAST=1, else to S_LO.
REQ-024 M_AXIS_TVALID SHALL assert on the cycle after the loading transfer (latency 1 cycle).
REQ-025 A header-only packet (TLAST on the header) SHALL emit one beat: TDATA=0, TSTRB=8'h00, TLAST=1.
REQ-026 M_AXIS_TVALID SHALL clear after a master transfer unless a new beat loads on the same cycle.
REQ-027 A simultaneous master transfer and output load SHALL keep M_AXIS_TVALID high with the new beat.
REQ-028 With no load pending, M_AXIS_TVALID SHALL stay high until a master transfer occurs.
REQ-029 While M_AXIS_TVALID is high, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST and M_AXIS_TUSER SHALL be stable.
REQ-030 M_AXIS_TUSER SHALL equal the current packet's header on every beat of that packet.
REQ-031 M_AXIS_TUSER SHALL change only on an S_HDR transfer.
REQ-032 Sustained throughput SHALL be one 64-bit beat per two input words when both sides are continuously ready.
REQ-033 Back-to-back packets SHALL incur at most one idle input cycle, spent in S_HDR draining the final beat.
REQ-034 S_AXIS_TVALID SHALL be ignored outside transfers; no input word SHALL be dropped or duplicated.

Reset
REQ-035 Reset SHALL return the state to S_HDR.
REQ-036 Reset SHALL clear M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST and M_AXIS_TUSER to 0, and the low-word register to 0.
REQ-037 S_AXIS_TREADY SHALL read 1 on the first cycle after reset deasserts.
REQ-038 Reset mid-packet SHALL discard all partial data; the next accepted word SHALL be treated as a header.

Structure
REQ-039 State encodings and the strobe constants (8'hFF, 8'h0F, 8'h00) SHALL be defined in the shared axis package, not local to this module.
REQ-040 The block SHALL be one flat module with no sub-modules.
REQ-041 The output register SHALL be the only storage on the master side; the block SHALL contain no FIFO.

Verification
REQ-042 Scenario: hdr A5A5_0001, words 1,2,3,4 (TLAST on 4), sink always ready -> 2 beats, both TUSER=A5A5_0001 and TSTRB=FF: 0x00000002_00000001 (TLAST=0), then 0x00000004_00000003 (TLAST=1).
REQ-043 Scenario: hdr 0x11, words 7,8,9 (TLAST on 9) -> beats 0x00000008_00000007/FF/TLAST=0 and 0x00000000_00000009/0F/TLAST=1.
REQ-044 Scenario: hdr 0x22 with TLAST=1 -> one beat TDATA=0, TSTRB=00, TLAST=1, TUSER=0x22.
REQ-045 Scenario: M_AXIS_TREADY low for 10 cycles mid-packet -> S_AXIS_TREADY drops once the output is full; output fields stable; no loss or duplication after release.
REQ-046 Scenario: back-to-back packets with hdr 0x33 then 0x44 while the sink stalls the last beat -> TUSER stays 0x33 until that beat transfers; header 0x44 accepted only after it.
REQ-047 Scenario: AXIS_ARESET asserted after an S_LO word is accepted, then packet hdr 0x55, words 1,2 -> single beat 0x00000002_00000001, TUSER=0x55, TSTRB=FF, TLAST=1.
